// File: rtl/instr_cache_dual_fetch.sv
// Direct-mapped, dual-lane instruction cache: two PCs per bundle, line refill on miss, replay.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_CNT_EN.
module instr_cache_dual_fetch #(
  parameter int instrWidth = 32,
  parameter int addrWidth  = 32,
  parameter int numLines   = 64,
  parameter int lineWords  = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  fetchValid,
  output logic                  fetchReady,
  input  logic [addrWidth-1:0]  pcF1,
  input  logic [addrWidth-1:0]  pcF2,
  output logic                  rspValid,
  output logic [instrWidth-1:0] instrF1,
  output logic [instrWidth-1:0] instrF2,
  input  logic                  flush,
  output logic                  memReqValid,
  input  logic                  memReqReady,
  output logic [addrWidth-1:0]  memReqAddr,
  input  logic                  memRespValid,
  input  logic [instrWidth-1:0] memRespData,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]           hitCount,
  output logic [31:0]           missCount,
`endif
  output logic [1:0]            dbgState
);
  // Handshakes: fetch bundle and refill request transfer on a cycle where valid & ready are
  // both high; valid holds its payload stable until then. Refill beats have no ready and are
  // consumed whenever they arrive in FILL.

  localparam int byteBits = $clog2(instrWidth / 8);
  localparam int offBits  = $clog2(lineWords);
  localparam int idxBits  = $clog2(numLines);
  localparam int lineLsb  = byteBits + offBits;
  localparam int tagBits  = addrWidth - lineLsb - idxBits;
  localparam logic [offBits-1:0] lastBeat = offBits'(lineWords - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, REQ, FILL} stateT;

  function automatic logic [idxBits-1:0] idxOf(input logic [addrWidth-1:0] a);
    return idxBits'(a >> lineLsb);
  endfunction

  function automatic logic [tagBits-1:0] tagOf(input logic [addrWidth-1:0] a);
    return tagBits'(a >> (lineLsb + idxBits));
  endfunction

  function automatic logic [offBits-1:0] offOf(input logic [addrWidth-1:0] a);
    return offBits'(a >> byteBits);
  endfunction

  function automatic logic [addrWidth-1:0] lineBase(input logic [addrWidth-1:0] a);
    return (a >> lineLsb) << lineLsb;
  endfunction

  logic [instrWidth-1:0] dataArr [numLines][lineWords];
  logic [tagBits-1:0]    tagArr  [numLines];
  logic [numLines-1:0]   validArr;

  stateT                 state, stateNext;
  logic [addrWidth-1:0]  pc1Q, pc2Q, reqAddrQ;
  logic [offBits-1:0]    beatQ;
  logic                  flushPendQ;
  logic [instrWidth-1:0] f2HoldQ;
  logic                  f2HeldQ;

  logic                  hit1, hit2, lookupHit, fillHitsF2, lastFillBeat;
  logic [addrWidth-1:0]  missPc;
  logic [idxBits-1:0]    fillIdx;

  assign hit1 = validArr[idxOf(pc1Q)] && (tagArr[idxOf(pc1Q)] == tagOf(pc1Q));
  // F2's word captured during its own refill keeps an index conflict with F1 from livelocking.
  assign hit2 = f2HeldQ || (validArr[idxOf(pc2Q)] && (tagArr[idxOf(pc2Q)] == tagOf(pc2Q)));
  assign lookupHit    = hit1 && hit2 && !flush;
  assign missPc       = (!hit1 || flush) ? pc1Q : pc2Q;
  assign fillIdx      = idxOf(reqAddrQ);
  assign fillHitsF2   = (lineBase(pc2Q) == reqAddrQ);
  assign lastFillBeat = (state == FILL) && memRespValid && (beatQ == lastBeat);

  always_comb begin
    stateNext   = state;
    fetchReady  = 1'b0;
    rspValid    = 1'b0;
    memReqValid = 1'b0;
    case (state)
      IDLE: begin
        fetchReady = 1'b1;
        if (fetchValid) stateNext = LOOKUP;
      end
      LOOKUP: begin
        if (lookupHit) begin
          rspValid   = 1'b1;
          fetchReady = 1'b1;
          stateNext  = fetchValid ? LOOKUP : IDLE;
        end else begin
          stateNext = REQ;
        end
      end
      REQ: begin
        memReqValid = 1'b1;
        if (memReqReady) stateNext = FILL;
      end
      FILL: begin
        if (lastFillBeat) stateNext = LOOKUP;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign instrF1    = rspValid ? dataArr[idxOf(pc1Q)][offOf(pc1Q)] : '0;
  assign instrF2    = !rspValid ? '0 : (f2HeldQ ? f2HoldQ : dataArr[idxOf(pc2Q)][offOf(pc2Q)]);
  assign memReqAddr = reqAddrQ;
  assign dbgState   = state;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      pc1Q       <= '0;
      pc2Q       <= '0;
      reqAddrQ   <= '0;
      beatQ      <= '0;
      flushPendQ <= 1'b0;
      f2HoldQ    <= '0;
      f2HeldQ    <= 1'b0;
      validArr   <= '0;
    end else begin
      state <= stateNext;
      if (fetchValid && fetchReady) begin
        pc1Q    <= pcF1;
        pc2Q    <= pcF2;
        f2HeldQ <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (flush) validArr <= '0;
        end
        LOOKUP: begin
          if (flush) begin
            validArr <= '0;
            f2HeldQ  <= 1'b0;
          end
          if (!lookupHit) reqAddrQ <= lineBase(missPc);
        end
        REQ: begin
          if (flush) flushPendQ <= 1'b1;
          beatQ <= '0;
        end
        FILL: begin
          if (flush) flushPendQ <= 1'b1;
          if (memRespValid) begin
            beatQ <= beatQ + 1'b1;
            if (fillHitsF2 && (beatQ == offOf(pc2Q))) f2HoldQ <= memRespData;
            if (beatQ == lastBeat) begin
              // A flush seen during the refill wipes everything, including the fresh line.
              if (flush || flushPendQ) begin
                validArr <= '0;
                f2HeldQ  <= 1'b0;
              end else begin
                validArr[fillIdx] <= 1'b1;
                if (fillHitsF2) f2HeldQ <= 1'b1;
              end
              flushPendQ <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && memRespValid) begin
      dataArr[fillIdx][beatQ] <= memRespData;
      if (beatQ == lastBeat) tagArr[fillIdx] <= tagOf(reqAddrQ);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (rspValid) hitCount <= hitCount + 32'd1;
      if (state == REQ && memReqReady) missCount <= missCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_dual_fetch.sv
// Directed bench for instr_cache_dual_fetch: vector table of bundles plus flush/reset sequences.
module tb_instr_cache_dual_fetch;
  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        fetchValid = 1'b0;
  logic        fetchReady;
  logic [31:0] pcF1 = '0, pcF2 = '0;
  logic        rspValid;
  logic [31:0] instrF1, instrF2;
  logic        flush = 1'b0;
  logic        memReqValid;
  logic        memReqReady = 1'b1;
  logic [31:0] memReqAddr;
  logic        memRespValid = 1'b0;
  logic [31:0] memRespData = '0;
  logic [1:0]  dbgState;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hitCount, missCount;
`endif

  instr_cache_dual_fetch dut (
    .clk(clk), .rstN(rstN), .fetchValid(fetchValid), .fetchReady(fetchReady),
    .pcF1(pcF1), .pcF2(pcF2), .rspValid(rspValid), .instrF1(instrF1), .instrF2(instrF2),
    .flush(flush), .memReqValid(memReqValid), .memReqReady(memReqReady),
    .memReqAddr(memReqAddr), .memRespValid(memRespValid), .memRespData(memRespData),
`ifdef ICACHE_PERF_CNT_EN
    .hitCount(hitCount), .missCount(missCount),
`endif
    .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int applied = 0;
  int miscompares = 0;
  logic [31:0] reqLog[$];
  logic [31:0] exp_q[$];
  int memGap = 0;
  int curBeat = 0;
  logic [31:0] memBase;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h60 + (a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // next-level memory: logs each request and streams the line with memGap idle cycles per beat
  initial begin
    forever begin
      @(negedge clk);
      if (rstN && memReqValid && memReqReady) begin
        memBase = memReqAddr;
        reqLog.push_back(memReqAddr);
        @(posedge clk);
        for (int b = 0; b < 4; b++) begin
          for (int g = 0; g < memGap; g++) begin
            #1 memRespValid = 1'b0;
            @(posedge clk);
          end
          #1;
          memRespValid = 1'b1;
          memRespData  = memWord(memBase + 32'(4 * b));
          curBeat      = b;
          @(posedge clk);
        end
        #1 memRespValid = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic applyReset();
    @(posedge clk);
    #1 rstN = 1'b0;
    fetchValid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic doFetch(input logic [31:0] p1, input logic [31:0] p2,
                         output logic [31:0] got1, output logic [31:0] got2, output int lat);
    bit accepted;
    accepted = 1'b0;
    got1 = 'x;
    got2 = 'x;
    lat = -1;
    @(posedge clk);
    #1;
    fetchValid = 1'b1;
    pcF1 = p1;
    pcF2 = p2;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (fetchReady) accepted = 1'b1;
    end
    @(posedge clk);
    #1 fetchValid = 1'b0;
    if (accepted) begin
      for (int c = 1; c <= 300; c++) begin
        @(negedge clk);
        if (rspValid) begin
          got1 = instrF1;
          got2 = instrF2;
          lat = c;
          break;
        end
      end
    end
  endtask

  task automatic checkRefills(input string name);
    logic [31:0] e, a;
    check({name, " refill count"}, 32'(reqLog.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (reqLog.size() > 0) ? reqLog.pop_front() : 'x;
      check({name, " refill addr"}, a, e);
    end
    reqLog.delete();
  endtask

  typedef struct {
    bit          doReset;
    logic [31:0] p1, p2;
    int          gap;
    int          expLat;
    logic [31:0] expI1, expI2;
    int          nReq;
    logic [31:0] r0, r1, r2;
  } vecT;

  vecT vecs[10];
  vecT b2b[3];

  initial begin
    logic [31:0] g1, g2;
    int lat;
    int expHits, expMiss;
    string nm;

    vecs[0] = '{1'b1, 32'h104, 32'h108, 0, 7,  32'hA1,  32'hA2,  1, 32'h100, 32'h0,   32'h0};
    vecs[1] = '{1'b0, 32'h100, 32'h10C, 0, 1,  32'hA0,  32'hA3,  0, 32'h0,   32'h0,   32'h0};
    vecs[2] = '{1'b1, 32'h10C, 32'h110, 0, 13, 32'hA3,  32'hA4,  2, 32'h100, 32'h110, 32'h0};
    vecs[3] = '{1'b0, 32'h114, 32'h104, 0, 1,  32'hA5,  32'hA1,  0, 32'h0,   32'h0,   32'h0};
    vecs[4] = '{1'b0, 32'h000, 32'h400, 0, 19, 32'h60,  32'h160, 3, 32'h0,   32'h400, 32'h0};
    vecs[5] = '{1'b0, 32'h004, 32'h00C, 0, 1,  32'h61,  32'h63,  0, 32'h0,   32'h0,   32'h0};
    vecs[6] = '{1'b0, 32'h404, 32'h404, 0, 7,  32'h161, 32'h161, 1, 32'h400, 32'h0,   32'h0};
    vecs[7] = '{1'b0, 32'h208, 32'h200, 0, 7,  32'hE2,  32'hE0,  1, 32'h200, 32'h0,   32'h0};
    vecs[8] = '{1'b0, 32'h300, 32'h304, 1, 11, 32'h120, 32'h121, 1, 32'h300, 32'h0,   32'h0};
    vecs[9] = '{1'b0, 32'h000, 32'h304, 0, 7,  32'h60,  32'h121, 1, 32'h0,   32'h0,   32'h0};
    b2b[0]  = '{1'b0, 32'h100, 32'h104, 0, 1,  32'hA0,  32'hA1,  0, 32'h0,   32'h0,   32'h0};
    b2b[1]  = '{1'b0, 32'h108, 32'h10C, 0, 1,  32'hA2,  32'hA3,  0, 32'h0,   32'h0,   32'h0};
    b2b[2]  = '{1'b0, 32'h110, 32'h114, 0, 1,  32'hA4,  32'hA5,  0, 32'h0,   32'h0,   32'h0};

    // reset values, checked while reset is held
    repeat (2) @(negedge clk);
    check("reset rspValid", 32'(rspValid), 32'd0);
    check("reset memReqValid", 32'(memReqValid), 32'd0);
    check("reset memReqAddr", memReqAddr, 32'h0);
    check("reset instrF1", instrF1, 32'h0);
    check("reset instrF2", instrF2, 32'h0);
    check("reset fetchReady", 32'(fetchReady), 32'd1);
    check("reset dbgState", 32'(dbgState), 32'd0);
    @(posedge clk);
    #1 rstN = 1'b1;

    expHits = 0;
    expMiss = 0;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].doReset) begin
        applyReset();
        expHits = 0;
        expMiss = 0;
      end
      memGap = vecs[i].gap;
      exp_q.delete();
      if (vecs[i].nReq > 0) exp_q.push_back(vecs[i].r0);
      if (vecs[i].nReq > 1) exp_q.push_back(vecs[i].r1);
      if (vecs[i].nReq > 2) exp_q.push_back(vecs[i].r2);
      doFetch(vecs[i].p1, vecs[i].p2, g1, g2, lat);
      nm = $sformatf("vec%0d", i);
      check({nm, " latency"}, 32'(lat), 32'(vecs[i].expLat));
      check({nm, " instrF1"}, g1, vecs[i].expI1);
      check({nm, " instrF2"}, g2, vecs[i].expI2);
      checkRefills(nm);
      expHits++;
      expMiss += vecs[i].nReq;
    end
    memGap = 0;
`ifdef ICACHE_PERF_CNT_EN
    check("hitCount", hitCount, 32'(expHits));
    check("missCount", missCount, 32'(expMiss));
`endif

    // back-to-back hits in line 0x100, one bundle per cycle
    @(posedge clk);
    #1;
    fetchValid = 1'b1;
    pcF1 = b2b[0].p1;
    pcF2 = b2b[0].p2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k < 2) begin
        pcF1 = b2b[k+1].p1;
        pcF2 = b2b[k+1].p2;
      end else begin
        fetchValid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("b2b%0d rspValid", k), 32'(rspValid), 32'd1);
      check($sformatf("b2b%0d instrF1", k), instrF1, b2b[k].expI1);
      check($sformatf("b2b%0d instrF2", k), instrF2, b2b[k].expI2);
      check($sformatf("b2b%0d memReqValid", k), 32'(memReqValid), 32'd0);
    end
    @(negedge clk);
    check("b2b pulse end", 32'(rspValid), 32'd0);
    exp_q.delete();
    checkRefills("b2b");

    // flush on refill beat 1: refill completes, replay misses, same line fetched again
    exp_q.delete();
    exp_q.push_back(32'h280);
    exp_q.push_back(32'h280);
    fork
      doFetch(32'h280, 32'h284, g1, g2, lat);
      begin
        for (int c = 0; c < 100; c++) begin
          @(posedge clk);
          #2;
          if (memRespValid && curBeat == 1) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            break;
          end
        end
      end
    join
    check("flushFill latency", 32'(lat), 32'd13);
    check("flushFill instrF1", g1, 32'h100);
    check("flushFill instrF2", g2, 32'h101);
    checkRefills("flushFill");

    exp_q.push_back(32'h100);
    doFetch(32'h100, 32'h104, g1, g2, lat);
    check("postFlush latency", 32'(lat), 32'd7);
    check("postFlush instrF1", g1, 32'hA0);
    checkRefills("postFlush");

    // flush while idle invalidates the line just refilled
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_q.push_back(32'h100);
    doFetch(32'h104, 32'h100, g1, g2, lat);
    check("idleFlush latency", 32'(lat), 32'd7);
    check("idleFlush instrF2", g2, 32'hA0);
    checkRefills("idleFlush");

    // reset while the refill request is stalled
    memReqReady = 1'b0;
    @(posedge clk);
    #1;
    fetchValid = 1'b1;
    pcF1 = 32'h704;
    pcF2 = 32'h704;
    @(posedge clk);
    #1 fetchValid = 1'b0;
    repeat (3) @(negedge clk);
    check("stall memReqValid", 32'(memReqValid), 32'd1);
    check("stall memReqAddr", memReqAddr, 32'h700);
    #2 rstN = 1'b0;
    #1;
    check("asyncReset memReqValid", 32'(memReqValid), 32'd0);
    check("asyncReset dbgState", 32'(dbgState), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    memReqReady = 1'b1;
    exp_q.delete();
    reqLog.delete();
    exp_q.push_back(32'h700);
    doFetch(32'h704, 32'h704, g1, g2, lat);
    check("afterReset latency", 32'(lat), 32'd7);
    check("afterReset instrF1", g1, 32'h221);
    checkRefills("afterReset");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
